// File: rtl/dense_layer_gen_if.sv
// Run/valid handshake and weight-ROM read bus of dense_layer_gen.
// master = the layer, slave = controller plus weight ROM.
interface dense_layer_gen_if #(
    parameter int unsigned AW  = 10,
    parameter int unsigned PAR = 8,
    parameter int unsigned DW  = 16
);
    logic              run;
    logic              valid;
    logic              sat;
    logic              w_en;
    logic [AW-1:0]     w_addr;
    logic [PAR*DW-1:0] w_data;

    modport master (input run, w_data, output valid, sat, w_en, w_addr);
    modport slave  (output run, w_data, input valid, sat, w_en, w_addr);
endinterface

// File: rtl/dense_layer_gen.sv
// Parametrised fixed-point dense layer, PAR output columns per weight word.
// Optional `define DENSE_RELU_EN applies ReLU after saturation.
module dense_layer_gen #(
    parameter int unsigned ROWS    = 10,
    parameter int unsigned IN_DIM  = 24,
    parameter int unsigned OUT_DIM = 200,
    parameter int unsigned DW      = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned PAR     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ROWS*IN_DIM*DW-1:0]  d,
    output logic [ROWS*OUT_DIM*DW-1:0] q,
    dense_layer_gen_if.master          bus
);
    localparam int unsigned GROUPS = OUT_DIM / PAR;
    localparam int unsigned ADDR_W = (IN_DIM * GROUPS > 1) ? $clog2(IN_DIM * GROUPS) : 1;
    localparam int unsigned HW     = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned NW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ACCW   = 2 * DW + $clog2(IN_DIM);

    localparam logic [HW-1:0] H_LAST = HW'(IN_DIM - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(ROWS - 1);

    localparam logic signed [ACCW-1:0] QMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] QMIN = ~QMAX;

    typedef enum logic [2:0] {StIdle, StMac, StDrain, StWrite, StDone} state_e;

    state_e                     state_q, state_d;
    logic [NW-1:0]              n_q;
    logic [GW-1:0]              g_q;
    logic [HW-1:0]              h_q;
    logic [HW-1:0]              hp_q;
    logic                       mac_vld_q;
    logic signed [ACCW-1:0]     acc_q [PAR];
    logic [ROWS*IN_DIM*DW-1:0]  d_q;
    logic [ROWS*OUT_DIM*DW-1:0] q_q;
    logic                       sat_q;
    logic                       valid_q;

    logic                       last_grp;
    int unsigned                q_base;
    logic signed [DW-1:0]       d_elem;
    logic signed [2*DW-1:0]     prod    [PAR];
    logic signed [ACCW-1:0]     shifted [PAR];
    logic [DW-1:0]              res     [PAR];
    logic [PAR-1:0]             clamp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.run) state_d = StMac;
            StMac:   if (h_q == H_LAST) state_d = StDrain;
            StDrain: state_d = StWrite;
            StWrite: state_d = last_grp ? StDone : StMac;
            // valid_q low marks the first DONE cycle, which always shows the result.
            StDone:  if (valid_q && !bus.run) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.w_en   = (state_q == StMac);
        bus.w_addr = '0;
        if (state_q == StMac) begin
            bus.w_addr = ADDR_W'(32'(h_q) * GROUPS + 32'(g_q));
        end
        bus.valid = valid_q;
        bus.sat   = sat_q;
    end

    assign q = q_q;

    always_comb begin
        last_grp = (n_q == N_LAST) && (g_q == G_LAST);
        q_base   = (32'(n_q) * GROUPS + 32'(g_q)) * PAR;
        d_elem   = d_q[(32'(n_q) * IN_DIM + 32'(hp_q)) * DW +: DW];
        clamp    = '0;
        for (int p = 0; p < PAR; p++) begin
            prod[p]    = d_elem * $signed(bus.w_data[p*DW +: DW]);
            shifted[p] = acc_q[p] >>> FRAC;
            if (shifted[p] > QMAX) begin
                res[p]   = {1'b0, {(DW-1){1'b1}}};
                clamp[p] = 1'b1;
            end else if (shifted[p] < QMIN) begin
                res[p]   = {1'b1, {(DW-1){1'b0}}};
                clamp[p] = 1'b1;
            end else begin
                res[p] = shifted[p][DW-1:0];
            end
`ifdef DENSE_RELU_EN
            if (res[p][DW-1]) res[p] = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q       <= '0;
            g_q       <= '0;
            h_q       <= '0;
            hp_q      <= '0;
            mac_vld_q <= 1'b0;
            d_q       <= '0;
            q_q       <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            for (int p = 0; p < PAR; p++) acc_q[p] <= '0;
        end else begin
            // Weight word arrives one cycle after its read, so the row index trails by one.
            mac_vld_q <= (state_q == StMac);
            hp_q      <= h_q;
            if (mac_vld_q) begin
                for (int p = 0; p < PAR; p++) acc_q[p] <= acc_q[p] + ACCW'(prod[p]);
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.run) begin
                        d_q   <= d;
                        n_q   <= '0;
                        g_q   <= '0;
                        h_q   <= '0;
                        sat_q <= 1'b0;
                        q_q   <= '0;
                        for (int p = 0; p < PAR; p++) acc_q[p] <= '0;
                    end
                end
                StMac: begin
                    h_q <= (h_q == H_LAST) ? '0 : h_q + 1'b1;
                end
                StWrite: begin
                    for (int p = 0; p < PAR; p++) begin
                        q_q[(q_base + 32'(p)) * DW +: DW] <= res[p];
                    end
                    if (|clamp) sat_q <= 1'b1;
                    for (int p = 0; p < PAR; p++) acc_q[p] <= '0;
                    if (last_grp) begin
                        g_q <= '0;
                        n_q <= '0;
                    end else if (g_q == G_LAST) begin
                        g_q <= '0;
                        n_q <= n_q + 1'b1;
                    end else begin
                        g_q <= g_q + 1'b1;
                    end
                end
                StDone: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (!bus.run) begin
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_gen.sv
// Scoreboard bench for dense_layer_gen: a small 2x4x4 instance for directed and random
// jobs and a default-parameter instance for one random full-size job.
module tb_dense_layer_gen;
    localparam int SR = 2, SI = 4, SO = 4, SP = 2, SG = SO / SP, SAW = 3;
    localparam int LR = 10, LI = 24, LO = 200, LP = 8, LG = LO / LP, LAW = 10;
    localparam int S_LAT = SR * SG * (SI + 2) + 1;
    localparam int L_LAT = LR * LG * (LI + 2) + 1;
    localparam int SQW = SR * SO * 16;
    localparam int LQW = LR * LO * 16;
`ifdef DENSE_RELU_EN
    localparam logic [15:0] NEG_EXP = 16'h0000;
    localparam logic [15:0] SNEG_EXP = 16'h0000;
`else
    localparam logic [15:0] NEG_EXP = 16'hFF40;
    localparam logic [15:0] SNEG_EXP = 16'h8000;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [SR*SI*16-1:0] d_s;
    logic [SQW-1:0]      q_s;
    logic [LR*LI*16-1:0] d_l;
    logic [LQW-1:0]      q_l;

    dense_layer_gen_if #(.AW(SAW), .PAR(SP), .DW(16)) bus_s ();
    dense_layer_gen_if #(.AW(LAW), .PAR(LP), .DW(16)) bus_l ();

    dense_layer_gen #(.ROWS(SR), .IN_DIM(SI), .OUT_DIM(SO), .DW(16), .FRAC(8), .PAR(SP)) dut_s (
        .clk(clk), .rst(rst), .d(d_s), .q(q_s), .bus(bus_s)
    );
    dense_layer_gen #(.ROWS(LR), .IN_DIM(LI), .OUT_DIM(LO), .DW(16), .FRAC(8), .PAR(LP)) dut_l (
        .clk(clk), .rst(rst), .d(d_l), .q(q_l), .bus(bus_l)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ld [LR][LI];
    int lw [LI][LO];
    int qm [LR][LO];

    logic [SQW-1:0] s_exp_q [$];
    bit             s_sat_q [$];
    int             s_start_q [$];
    int             s_addr_q [$];
    logic [SQW-1:0] s_last;
    logic [LQW-1:0] l_exp_q [$];
    bit             l_sat_q [$];
    int             l_start_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected / did not occur", name);
    endtask

    task automatic cmp_s(input string name, input logic [SQW-1:0] act, input logic [SQW-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int i = SR * SO - 1; i >= 0; i--) if (act[i*16 +: 16] !== exp[i*16 +: 16]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: element %0d got 0x%0h, expected 0x%0h", name, bad,
                     act[bad*16 +: 16], exp[bad*16 +: 16]);
        end
    endtask

    task automatic cmp_l(input string name, input logic [LQW-1:0] act, input logic [LQW-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int i = LR * LO - 1; i >= 0; i--) if (act[i*16 +: 16] !== exp[i*16 +: 16]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: element %0d got 0x%0h, expected 0x%0h", name, bad,
                     act[bad*16 +: 16], exp[bad*16 +: 16]);
        end
    endtask

    // Reference: exact integer dot product, floor shift, clamp, optional ReLU.
    function automatic bit model(input int rows, input int ind, input int outd);
        bit s;
        longint acc;
        s = 1'b0;
        for (int n = 0; n < rows; n++) begin
            for (int c = 0; c < outd; c++) begin
                acc = 0;
                for (int h = 0; h < ind; h++) acc += longint'(ld[n][h]) * longint'(lw[h][c]);
                acc = acc >>> 8;
                if (acc > 32767) begin
                    acc = 32767;
                    s = 1'b1;
                end else if (acc < -32768) begin
                    acc = -32768;
                    s = 1'b1;
                end
`ifdef DENSE_RELU_EN
                if (acc < 0) acc = 0;
`endif
                qm[n][c] = int'(acc);
            end
        end
        return s;
    endfunction

    task automatic clear_mem();
        for (int n = 0; n < LR; n++) for (int h = 0; h < LI; h++) ld[n][h] = 0;
        for (int h = 0; h < LI; h++) for (int c = 0; c < LO; c++) lw[h][c] = 0;
    endtask

    task automatic fill(input int dmag, input int wmag);
        for (int n = 0; n < LR; n++)
            for (int h = 0; h < LI; h++) ld[n][h] = int'($urandom_range(2 * dmag - 1, 0)) - dmag;
        for (int h = 0; h < LI; h++)
            for (int c = 0; c < LO; c++) lw[h][c] = int'($urandom_range(2 * wmag - 1, 0)) - wmag;
    endtask

    task automatic set_identity();
        clear_mem();
        for (int h = 0; h < SI; h++) begin
            ld[0][h] = (h + 1) * 256;
            lw[h][h] = 256;
        end
        ld[1][0] = -256;
        ld[1][1] = 128;
        ld[1][3] = 640;
    endtask

    // Weight ROMs: one-cycle read latency, lane p = w[h][g*PAR+p].
    initial forever begin
        @(posedge clk);
        if (bus_s.w_en)
            for (int p = 0; p < SP; p++)
                bus_s.w_data[p*16 +: 16] <=
                    16'(lw[int'(bus_s.w_addr) / SG][(int'(bus_s.w_addr) % SG) * SP + p]);
        if (bus_l.w_en)
            for (int p = 0; p < LP; p++)
                bus_l.w_data[p*16 +: 16] <=
                    16'(lw[int'(bus_l.w_addr) / LG][(int'(bus_l.w_addr) % LG) * LP + p]);
    end

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    initial forever begin
        @(negedge clk);
        if (!rst && bus_s.w_en) begin
            if (s_addr_q.size() == 0) fail("s_addr_extra");
            else check("s_w_addr", 64'(bus_s.w_addr), 64'(s_addr_q.pop_front()));
        end
    end

    initial begin : mon_s
        bit vprev;
        logic [SQW-1:0] e;
        bit es;
        int st;
        vprev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                vprev = 1'b0;
            end else begin
                if (bus_s.valid && !vprev) begin
                    if (s_exp_q.size() == 0) begin
                        fail("s_unexpected_valid");
                    end else begin
                        e  = s_exp_q.pop_front();
                        es = s_sat_q.pop_front();
                        st = s_start_q.pop_front();
                        cmp_s("s_q", q_s, e);
                        check("s_sat", 64'(bus_s.sat), 64'(es));
                        check("s_latency", 64'(cyc - st), 64'(S_LAT));
                        s_last = e;
                    end
                end else if (bus_s.valid) begin
                    cmp_s("s_q_hold", q_s, s_last);
                end
                vprev = bus_s.valid;
            end
        end
    end

    initial begin : mon_l
        bit vprev;
        logic [LQW-1:0] e;
        bit es;
        int st;
        vprev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                vprev = 1'b0;
            end else begin
                if (bus_l.valid && !vprev) begin
                    if (l_exp_q.size() == 0) begin
                        fail("l_unexpected_valid");
                    end else begin
                        e  = l_exp_q.pop_front();
                        es = l_sat_q.pop_front();
                        st = l_start_q.pop_front();
                        cmp_l("l_q", q_l, e);
                        check("l_sat", 64'(bus_l.sat), 64'(es));
                        check("l_latency", 64'(cyc - st), 64'(L_LAT));
                    end
                end
                vprev = bus_l.valid;
            end
        end
    end

    task automatic job_s(input int hold, input bit pulse, input int abort_at);
        logic [SQW-1:0] e;
        bit es;
        int k;
        for (int n = 0; n < SR; n++)
            for (int h = 0; h < SI; h++) d_s[(n*SI+h)*16 +: 16] = 16'(ld[n][h]);
        es = model(SR, SI, SO);
        for (int n = 0; n < SR; n++)
            for (int c = 0; c < SO; c++) e[(n*SO+c)*16 +: 16] = 16'(qm[n][c]);
        for (int n = 0; n < SR; n++)
            for (int g = 0; g < SG; g++)
                for (int h = 0; h < SI; h++) s_addr_q.push_back(h * SG + g);
        @(negedge clk);
        s_exp_q.push_back(e);
        s_sat_q.push_back(es);
        s_start_q.push_back(cyc + 1);
        bus_s.run = 1'b1;
        @(posedge clk);
        #1;
        check("s_start_sat_clr", 64'(bus_s.sat), 64'(0));
        cmp_s("s_start_q_clr", q_s, '0);
        d_s = {$urandom, $urandom, $urandom, $urandom};
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clk);
            rst = 1'b1;
            bus_s.run = 1'b0;
            @(posedge clk);
            #1;
            check("abort_valid", 64'(bus_s.valid), 64'(0));
            check("abort_w_en", 64'(bus_s.w_en), 64'(0));
            check("abort_w_addr", 64'(bus_s.w_addr), 64'(0));
            check("abort_sat", 64'(bus_s.sat), 64'(0));
            cmp_s("abort_q", q_s, '0);
            s_exp_q.delete();
            s_sat_q.delete();
            s_start_q.delete();
            s_addr_q.delete();
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            return;
        end
        if (pulse) begin
            @(negedge clk);
            bus_s.run = 1'b0;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_s.valid && k < 4 * S_LAT);
        if (!bus_s.valid) begin
            fail("s_valid_timeout");
            bus_s.run = 1'b0;
            s_exp_q.delete();
            s_sat_q.delete();
            s_start_q.delete();
            s_addr_q.delete();
            repeat (3) @(negedge clk);
            return;
        end
        if (!pulse) begin
            repeat (hold) @(negedge clk);
            bus_s.run = 1'b0;
        end
        @(posedge clk);
        #1;
        check("s_valid_drop", 64'(bus_s.valid), 64'(0));
        cmp_s("s_q_kept", q_s, e);
        @(negedge clk);
    endtask

    task automatic job_l();
        logic [LQW-1:0] e;
        bit es;
        int k;
        for (int n = 0; n < LR; n++)
            for (int h = 0; h < LI; h++) d_l[(n*LI+h)*16 +: 16] = 16'(ld[n][h]);
        es = model(LR, LI, LO);
        for (int n = 0; n < LR; n++)
            for (int c = 0; c < LO; c++) e[(n*LO+c)*16 +: 16] = 16'(qm[n][c]);
        @(negedge clk);
        l_exp_q.push_back(e);
        l_sat_q.push_back(es);
        l_start_q.push_back(cyc + 1);
        bus_l.run = 1'b1;
        @(posedge clk);
        #1;
        check("l_start_sat_clr", 64'(bus_l.sat), 64'(0));
        d_l = '0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_l.valid && k < 2 * L_LAT);
        if (!bus_l.valid) fail("l_valid_timeout");
        @(negedge clk);
        bus_l.run = 1'b0;
        @(posedge clk);
        #1;
        check("l_valid_drop", 64'(bus_l.valid), 64'(0));
        cmp_l("l_q_kept", q_l, e);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_s.run = 1'b0;
        bus_l.run = 1'b0;
        d_s = '0;
        d_l = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus_s.valid), 64'(0));
        check("rst_sat", 64'(bus_s.sat), 64'(0));
        check("rst_w_en", 64'(bus_s.w_en), 64'(0));
        check("rst_w_addr", 64'(bus_s.w_addr), 64'(0));
        cmp_s("rst_q", q_s, '0);
        check("rst_l_valid", 64'(bus_l.valid), 64'(0));
        cmp_l("rst_l_q", q_l, '0);
        @(negedge clk);
        rst = 1'b0;

        set_identity();
        job_s(100, 1'b0, 0);
        for (int c = 0; c < SO; c++) check("ident_row0", 64'(q_s[c*16 +: 16]), 64'((c + 1) * 256));

        clear_mem();
        ld[0][0] = -384;
        lw[0][0] = 128;
        job_s(2, 1'b1, 0);
        check("neg_trunc", 64'(q_s[15:0]), 64'(NEG_EXP));

        clear_mem();
        for (int n = 0; n < SR; n++) for (int h = 0; h < SI; h++) ld[n][h] = 32512;
        for (int h = 0; h < SI; h++) for (int c = 0; c < SO; c++) lw[h][c] = 32512;
        job_s(3, 1'b0, 0);
        check("sat_pos_flag", 64'(bus_s.sat), 64'(1));
        check("sat_pos_q", 64'(q_s[15:0]), 64'(16'h7FFF));
        for (int h = 0; h < SI; h++) for (int c = 0; c < SO; c++) lw[h][c] = -32512;
        job_s(3, 1'b0, 0);
        check("sat_neg_flag", 64'(bus_s.sat), 64'(1));
        check("sat_neg_q", 64'(q_s[SQW-1 -: 16]), 64'(SNEG_EXP));

        fill(64, 64);
        job_s(2, 1'b0, 0);
        check("sat_cleared", 64'(bus_s.sat), 64'(0));

        set_identity();
        job_s(0, 1'b0, 10);
        job_s(1, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            if (i < 3) fill(1024, 1024);
            else fill(32768, 32768);
            job_s(i % 3, 1'(i % 2), 0);
        end

        fill(1024, 512);
        job_l();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
